// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg: shared types and constants for the OFDM transmit chain.
// Holds the standard-select codes, per-standard FFT / cyclic-prefix sizes,
// the cyclic-prefix stage state enum and the packed I/Q sample width.
package ofdm_tx_pkg;

  // Packed sample: I in [31:16], Q in [15:0].
  localparam int SAMPLE_W = 32;

  // Counter width able to hold the longest symbol plus prefix (2048 + 512).
  localparam int CNT_W = 12;

  localparam logic [1:0] STD_80211 = 2'b00;
  localparam logic [1:0] STD_80216 = 2'b01;
  localparam logic [1:0] STD_80222 = 2'b10;
  localparam logic [1:0] STD_RSVD  = 2'b11;

  localparam logic [CNT_W-1:0] N_80211   = 12'd64;
  localparam logic [CNT_W-1:0] NCP_80211 = 12'd16;
  localparam logic [CNT_W-1:0] N_80216   = 12'd256;
  localparam logic [CNT_W-1:0] NCP_80216 = 12'd64;
  localparam logic [CNT_W-1:0] N_80222   = 12'd2048;
  localparam logic [CNT_W-1:0] NCP_80222 = 12'd512;

  typedef struct packed {
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] ncp;
  } sym_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PREF,
    ST_OUT
  } cp_state_e;

  // Symbol and prefix length for a standard code; the reserved code
  // falls back to 802.11 sizing.
  function automatic sym_size_t sym_size(input logic [1:0] std_sel);
    sym_size_t s;
    s = '0;
    case (std_sel)
      STD_80216: begin s.n = N_80216; s.ncp = NCP_80216; end
      STD_80222: begin s.n = N_80222; s.ncp = NCP_80222; end
      STD_80211,
      STD_RSVD:  begin s.n = N_80211; s.ncp = NCP_80211; end
      default:   begin s.n = N_80211; s.ncp = NCP_80211; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cp_sym_ram.sv
// cp_sym_ram: single-port symbol buffer, 2^AW x DW, one registered read.
// Ports: clk_i; we_i/addr_i/wdat_i write; re_i/addr_i read, rdat_o valid the
// cycle after re_i and held until the next read.
module cp_sym_ram #(
  parameter int DW = 32,
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdat_i,
  output logic [DW-1:0] rdat_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdat_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdat_i;
    if (re_i) rdat_q <= mem_q[addr_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/cp_insert.sv
// cp_insert: buffers one OFDM symbol, then emits its last NCP samples followed
// by the whole symbol. First STB_O two cycles after the last input is accepted.
// Back-pressure: ACK_O only in FILL; ACK_I stalls hold DAT_O/STB_O via a skid.
// Ports: CLK_I, RST_I (sync, active high); input side DAT_I/CYC_I/STB_I/WE_I/
// ACK_O; output side DAT_O/CYC_O/STB_O/WE_O/ACK_I; STD selects the standard.
// Build option CP_BYPASS_EN adds CP_BYP, which suppresses the prefix per frame.
module cp_insert
  import ofdm_tx_pkg::*;
#(
  parameter int DW = SAMPLE_W,
  parameter int AW = 11
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I,
  input  logic [1:0]    STD
`ifdef CP_BYPASS_EN
  ,
  input  logic          CP_BYP
`endif
);

  cp_state_e        state_q, state_d;
  logic             icyc_q;
  logic [1:0]       std_q, std_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_k_q, rd_k_d;      // next symbol index to read from RAM
  logic [CNT_W-1:0] out_k_q, out_k_d;    // index of the sample on DAT_O
  logic             skid_vld_q, skid_vld_d;
  logic [DW-1:0]    skid_q, skid_d;
  logic             cyc_o_q, cyc_o_d;
`ifdef CP_BYPASS_EN
  logic             byp_q, byp_d;
`endif

  sym_size_t        sz;
  logic [CNT_W-1:0] n_len, ncp_len, total_len;
  logic             frame_rise, new_frame;
  logic             stb, out_acc, last_acc;
  logic             ram_re, ram_we;
  logic [AW-1:0]    rd_addr, ram_addr;
  logic [DW-1:0]    ram_rdat;

  assign sz      = sym_size(std_q);
  assign n_len   = sz.n;
`ifdef CP_BYPASS_EN
  assign ncp_len = byp_q ? '0 : sz.ncp;
`else
  assign ncp_len = sz.ncp;
`endif
  assign total_len = n_len + ncp_len;

  assign frame_rise = CYC_I & ~icyc_q;
  assign ACK_O      = CYC_I & STB_I & WE_I & (state_q == ST_FILL);
  assign stb        = (state_q == ST_OUT);
  assign out_acc    = stb & ACK_I;
  assign last_acc   = out_acc & (out_k_q == total_len - CNT_W'(1));

  // A read is issued once per sample: in PREF for k = 0, then whenever the
  // RAM output (not the skid) is what DAT_O shows, i.e. a fresh sample landed.
  assign ram_re  = (state_q == ST_PREF) |
                   (stb & ~skid_vld_q & (rd_k_q != total_len));
  assign ram_we  = ACK_O;
  assign rd_addr = (rd_k_q < ncp_len) ? AW'(n_len - ncp_len + rd_k_q)
                                      : AW'(rd_k_q - ncp_len);
  assign ram_addr = ram_we ? wr_cnt_q[AW-1:0] : rd_addr;

  cp_sym_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk_i  (CLK_I),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdat_i (DAT_I),
    .rdat_o (ram_rdat)
  );

  always_comb begin
    state_d    = state_q;
    std_d      = std_q;
    wr_cnt_d   = wr_cnt_q;
    rd_k_d     = rd_k_q;
    out_k_d    = out_k_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    cyc_o_d    = cyc_o_q;
    new_frame  = 1'b0;
`ifdef CP_BYPASS_EN
    byp_d      = byp_q;
`endif
    if (ram_re) rd_k_d = rd_k_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (frame_rise) begin
          state_d    = ST_FILL;
          wr_cnt_d   = '0;
          rd_k_d     = '0;
          out_k_d    = '0;
          skid_vld_d = 1'b0;
          new_frame  = 1'b1;
        end
      end
      ST_FILL: begin
        // Frame ended before a full symbol: discard whatever was written.
        if (!CYC_I) begin
          state_d = ST_IDLE;
        end else if (ACK_O) begin
          if (wr_cnt_q == n_len - CNT_W'(1)) begin
            state_d = ST_PREF;
            rd_k_d  = '0;
            out_k_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PREF: begin
        state_d    = ST_OUT;
        cyc_o_d    = 1'b1;
        skid_vld_d = 1'b0;
      end
      ST_OUT: begin
        // The read for k+1 is already in flight when k is shown, so a stalled
        // RAM-sourced sample must move to the skid before the RAM overwrites it.
        if (skid_vld_q) begin
          if (ACK_I) skid_vld_d = 1'b0;
        end else if (!ACK_I) begin
          skid_vld_d = 1'b1;
          skid_d     = ram_rdat;
        end
        if (out_acc) out_k_d = out_k_q + CNT_W'(1);
        if (last_acc) begin
          out_k_d    = '0;
          rd_k_d     = '0;
          skid_vld_d = 1'b0;
          if (CYC_I) begin
            state_d   = ST_FILL;
            wr_cnt_d  = '0;
            new_frame = frame_rise;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (new_frame) begin
      std_d = STD;
`ifdef CP_BYPASS_EN
      byp_d = CP_BYP;
`endif
    end
    if (state_d == ST_IDLE) cyc_o_d = 1'b0;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      icyc_q     <= 1'b0;
      std_q      <= STD_80211;
      wr_cnt_q   <= '0;
      rd_k_q     <= '0;
      out_k_q    <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      cyc_o_q    <= 1'b0;
`ifdef CP_BYPASS_EN
      byp_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      icyc_q     <= CYC_I;
      std_q      <= std_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_k_q     <= rd_k_d;
      out_k_q    <= out_k_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      cyc_o_q    <= cyc_o_d;
`ifdef CP_BYPASS_EN
      byp_q      <= byp_d;
`endif
    end
  end

  assign STB_O = stb;
  assign WE_O  = stb;
  assign CYC_O = cyc_o_q;
  assign DAT_O = stb ? (skid_vld_q ? skid_q : ram_rdat) : '0;

endmodule
